// File: rtl/station_scheduler.sv
// rtl/station_scheduler.sv - age-ordered issue scheduler for the reservation stations
// Allocates free stations, tracks relative age, and issues the oldest ready hazard-free station.
module station_scheduler #(
  parameter int NUM_ST = 4,
  parameter int SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  output logic [NUM_ST-1:0]     st_feed,
  input  logic [NUM_ST-1:0]     st_complete,
  input  logic [NUM_ST-1:0]     st_ready,
  input  logic [NUM_ST-1:0]     st_will_complete,
  input  logic [NUM_ST-1:0]     st_ld_mem,
  input  logic [NUM_ST-1:0]     st_lock_loads,
  input  logic [3*NUM_ST-1:0]   st_a_adr,
  input  logic [3*NUM_ST-1:0]   st_b_adr,
  input  logic [4*NUM_ST-1:0]   st_d_adr,
  input  logic [4*NUM_ST-1:0]   st_lock_wr,
  input  logic [9*NUM_ST-1:0]   st_lock_rd,
  input  logic                  exe_stall,
  output logic [NUM_ST-1:0]     st_ack,
  output logic                  iss_valid,
  output logic [SEL_W-1:0]      iss_sel,
  output logic                  iss_retire,
  output logic [NUM_ST-1:0]     inflight
);

  logic [NUM_ST-1:0]             valid;
  logic [NUM_ST-1:0][NUM_ST-1:0] age;  // age[i][j]: station i is older than station j
  logic [NUM_ST-1:0]             free;
  logic [NUM_ST-1:0]             feed_sel;
  logic [NUM_ST-1:0]             blocked;
  logic [NUM_ST-1:0]             eligible;
  logic [SEL_W-1:0]              ack_idx;
  logic                          raw, war, waw, mem;

  always_comb begin
    free     = ~valid & st_complete;
    feed_sel = '0;
    for (int i = NUM_ST - 1; i >= 0; i--) begin
      if (free[i]) begin
        feed_sel    = '0;
        feed_sel[i] = 1'b1;
      end
    end
  end

  assign dec_ready = |free;
  assign st_feed   = dec_valid ? feed_sel : '0;
  assign inflight  = valid;

  // Station i is blocked by any valid older station j that it conflicts with.
  always_comb begin
    blocked = '0;
    raw = 1'b0;
    war = 1'b0;
    waw = 1'b0;
    mem = 1'b0;
    for (int i = 0; i < NUM_ST; i++) begin
      for (int j = 0; j < NUM_ST; j++) begin
        raw = st_lock_wr[4*j+3] &
              ((st_lock_wr[4*j +: 3] == st_a_adr[3*i +: 3]) |
               (st_lock_wr[4*j +: 3] == st_b_adr[3*i +: 3]));
        war = st_d_adr[4*i+3] &
              ((st_d_adr[4*i +: 3] == st_lock_rd[9*j +: 3]) |
               (st_d_adr[4*i +: 3] == st_lock_rd[9*j+3 +: 3]) |
               (st_d_adr[4*i +: 3] == st_lock_rd[9*j+6 +: 3]));
        waw = st_d_adr[4*i+3] & st_lock_wr[4*j+3] &
              (st_d_adr[4*i +: 3] == st_lock_wr[4*j +: 3]);
        mem = st_ld_mem[i] & st_lock_loads[j];
        if ((j != i) && valid[j] && age[j][i] && (raw || war || waw || mem))
          blocked[i] = 1'b1;
      end
    end
  end

  assign eligible = valid & st_ready & ~blocked & {NUM_ST{~exe_stall}};

  always_comb begin
    st_ack  = eligible;
    ack_idx = '0;
    for (int i = 0; i < NUM_ST; i++) begin
      for (int j = 0; j < NUM_ST; j++) begin
        if ((j != i) && eligible[j] && age[j][i])
          st_ack[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_ST; i++) begin
      if (st_ack[i])
        ack_idx = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      valid      <= '0;
      age        <= '0;
      iss_valid  <= 1'b0;
      iss_sel    <= '0;
      iss_retire <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_ST; k++) begin
        if (st_feed[k]) begin
          valid[k] <= 1'b1;
          age[k]   <= '0;
          for (int j = 0; j < NUM_ST; j++) begin
            if (j != k)
              age[j][k] <= valid[j];
          end
        end
      end
      // A fed station is never acked in the same cycle, so these never collide.
      for (int i = 0; i < NUM_ST; i++) begin
        if (st_ack[i] && st_will_complete[i])
          valid[i] <= 1'b0;
      end
      iss_valid  <= |st_ack;
      if (|st_ack)
        iss_sel <= ack_idx;
      iss_retire <= |(st_ack & st_will_complete);
    end
  end

endmodule

// File: tb/tb_station_scheduler.sv
// tb/tb_station_scheduler.sv - directed and randomized bench for station_scheduler
// Reference model orders stations by allocation sequence number instead of an age matrix.
module tb_station_scheduler;

  logic        clk;
  logic        a_rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  st_feed;
  logic [3:0]  st_complete, st_ready, st_will_complete, st_ld_mem, st_lock_loads;
  logic [11:0] st_a_adr, st_b_adr;
  logic [15:0] st_d_adr, st_lock_wr;
  logic [35:0] st_lock_rd;
  logic        exe_stall;
  logic [3:0]  st_ack;
  logic        iss_valid;
  logic [1:0]  iss_sel;
  logic        iss_retire;
  logic [3:0]  inflight;

  station_scheduler #(.NUM_ST(4), .SEL_W(2)) dut (
    .clk(clk), .a_rst(a_rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .st_feed(st_feed), .st_complete(st_complete), .st_ready(st_ready),
    .st_will_complete(st_will_complete), .st_ld_mem(st_ld_mem),
    .st_lock_loads(st_lock_loads), .st_a_adr(st_a_adr), .st_b_adr(st_b_adr),
    .st_d_adr(st_d_adr), .st_lock_wr(st_lock_wr), .st_lock_rd(st_lock_rd),
    .exe_stall(exe_stall), .st_ack(st_ack), .iss_valid(iss_valid),
    .iss_sel(iss_sel), .iss_retire(iss_retire), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  bit m_valid [4];
  int m_seq [4];
  int seq_ctr;
  bit m_iss_valid;
  int m_iss_sel;
  bit m_iss_retire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_seq[i] = 0;
    end
    seq_ctr = 0;
    m_iss_valid = 0;
    m_iss_sel = 0;
    m_iss_retire = 0;
  endtask

  // j is the older station, i the younger one
  function automatic bit conflict(int j, int i);
    logic [2:0] wr, d, a, b, r0, r1, r2;
    bit raw, war, waw, mem;
    wr = st_lock_wr[4*j +: 3];
    d  = st_d_adr[4*i +: 3];
    a  = st_a_adr[3*i +: 3];
    b  = st_b_adr[3*i +: 3];
    r0 = st_lock_rd[9*j +: 3];
    r1 = st_lock_rd[9*j+3 +: 3];
    r2 = st_lock_rd[9*j+6 +: 3];
    raw = st_lock_wr[4*j+3] && (wr == a || wr == b);
    war = st_d_adr[4*i+3] && (d == r0 || d == r1 || d == r2);
    waw = st_d_adr[4*i+3] && st_lock_wr[4*j+3] && (d == wr);
    mem = st_ld_mem[i] && st_lock_loads[j];
    return raw || war || waw || mem;
  endfunction

  function automatic int model_pick();
    int best = -1;
    bit blk;
    for (int i = 0; i < 4; i++) begin
      blk = 0;
      for (int j = 0; j < 4; j++)
        if (j != i && m_valid[j] && m_seq[j] < m_seq[i] && conflict(j, i)) blk = 1;
      if (m_valid[i] && st_ready[i] && !exe_stall && !blk)
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
    end
    return best;
  endfunction

  task automatic cycle(input int want_ack = -1, input int want_feed = -1);
    int fi, ai;
    logic [3:0] ef, ea, wc;
    bit er, dv;
    @(negedge clk);
    fi = -1;
    for (int i = 3; i >= 0; i--) if (!m_valid[i] && st_complete[i]) fi = i;
    er = (fi >= 0);
    dv = dec_valid;
    ef = '0;
    if (er && dv) ef[fi] = 1'b1;
    ai = model_pick();
    ea = '0;
    if (ai >= 0) ea[ai] = 1'b1;
    wc = st_will_complete;
    check("dec_ready", 32'(dec_ready), 32'(er));
    check("st_feed", 32'(st_feed), 32'(ef));
    check("st_ack", 32'(st_ack), 32'(ea));
    if (want_ack >= 0) check("dir_ack", 32'(st_ack), want_ack);
    if (want_feed >= 0) check("dir_feed", 32'(st_feed), want_feed);
    @(posedge clk);
    #1;
    if (er && dv) begin
      m_valid[fi] = 1;
      m_seq[fi] = seq_ctr++;
    end
    m_iss_valid = (ai >= 0);
    m_iss_retire = (ai >= 0) && wc[ai];
    if (ai >= 0) begin
      m_iss_sel = ai;
      if (wc[ai]) m_valid[ai] = 0;
    end
    check("iss_valid", 32'(iss_valid), 32'(m_iss_valid));
    check("iss_sel", 32'(iss_sel), m_iss_sel);
    check("iss_retire", 32'(iss_retire), 32'(m_iss_retire));
    check("inflight", 32'(inflight),
          32'({m_valid[3], m_valid[2], m_valid[1], m_valid[0]}));
  endtask

  task automatic idle();
    dec_valid = 0;
    st_complete = 4'b1111;
    st_ready = 0;
    st_will_complete = 0;
    st_ld_mem = 0;
    st_lock_loads = 0;
    st_a_adr = 0;
    st_b_adr = 0;
    st_d_adr = 0;
    st_lock_wr = 0;
    st_lock_rd = 0;
    exe_stall = 0;
  endtask

  task automatic do_reset();
    idle();
    a_rst = 1;
    @(posedge clk);
    #1;
    a_rst = 0;
    model_clear();
  endtask

  initial begin
    model_clear();
    idle();
    a_rst = 1;
    @(posedge clk);
    #1;
    check("rst_inflight", 32'(inflight), 0);
    check("rst_iss_valid", 32'(iss_valid), 0);
    a_rst = 0;
    #1;
    check("rst_dec_ready", 32'(dec_ready), 1);
    check("rst_st_feed", 32'(st_feed), 0);
    check("rst_st_ack", 32'(st_ack), 0);
    cycle(0, 0);

    // allocation fills lowest index first, then reports full
    dec_valid = 1;
    cycle(-1, 4'b0001);
    cycle(-1, 4'b0010);
    cycle(-1, 4'b0100);
    cycle(-1, 4'b1000);
    cycle(0, 0);
    check("full_dec_ready", 32'(dec_ready), 0);

    // age ordering: S2 fed before S0
    do_reset();
    dec_valid = 1;
    st_complete = 4'b0100;
    cycle(-1, 4'b0100);
    st_complete = 4'b0001;
    cycle(-1, 4'b0001);
    dec_valid = 0;
    st_complete = 4'b1111;
    st_ready = 4'b0101;
    st_will_complete = 4'b0101;
    cycle(4'b0100);
    check("age_sel2", 32'(iss_sel), 2);
    cycle(4'b0001);
    check("age_sel0", 32'(iss_sel), 0);
    st_ready = 0;
    cycle(0);

    // RAW: older S1 writes r3, younger S3 reads r3
    do_reset();
    dec_valid = 1;
    st_complete = 4'b0010;
    cycle(-1, 4'b0010);
    st_complete = 4'b1000;
    cycle(-1, 4'b1000);
    dec_valid = 0;
    st_complete = 4'b1111;
    st_lock_wr[7:4] = 4'b1011;
    st_a_adr[11:9] = 3'd3;
    st_ready = 4'b1000;
    cycle(0);
    st_ready = 4'b1010;
    st_will_complete = 4'b0010;
    cycle(4'b0010);
    cycle(4'b1000);

    // MEM: S1 load waits on S0 lock_loads, S2 ALU-only passes
    do_reset();
    dec_valid = 1;
    cycle(-1, 4'b0001);
    cycle(-1, 4'b0010);
    cycle(-1, 4'b0100);
    dec_valid = 0;
    st_lock_loads = 4'b0001;
    st_ld_mem = 4'b0010;
    st_ready = 4'b0110;
    cycle(4'b0100);
    st_ready = 4'b0010;
    cycle(0);
    st_ready = 4'b0011;
    st_will_complete = 4'b0001;
    cycle(4'b0001);
    cycle(4'b0010);

    // stall, then asynchronous reset with three stations in flight
    do_reset();
    dec_valid = 1;
    cycle(-1, 4'b0001);
    dec_valid = 0;
    st_ready = 4'b0001;
    exe_stall = 1;
    cycle(0);
    check("stall_iss_valid", 32'(iss_valid), 0);
    exe_stall = 0;
    st_ready = 0;
    dec_valid = 1;
    cycle(-1, 4'b0010);
    cycle(-1, 4'b0100);
    dec_valid = 0;
    check("pre_rst_inflight", 32'(inflight), 32'(4'b0111));
    a_rst = 1;
    #1;
    check("async_inflight", 32'(inflight), 0);
    check("async_dec_ready", 32'(dec_ready), 1);
    @(posedge clk);
    #1;
    a_rst = 0;
    model_clear();
    idle();

    // randomized traffic against the sequence-number model
    for (int c = 0; c < 400; c++) begin
      dec_valid = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < 4; i++) st_complete[i] = ($urandom_range(0, 9) < 8);
      st_ready = 4'($urandom);
      st_will_complete = 4'($urandom);
      st_ld_mem = 4'($urandom) & 4'($urandom);
      st_lock_loads = 4'($urandom) & 4'($urandom);
      st_a_adr = 12'($urandom);
      st_b_adr = 12'($urandom);
      st_d_adr = 16'($urandom);
      st_lock_wr = 16'($urandom);
      st_lock_rd = {4'($urandom), 32'($urandom)};
      exe_stall = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
